// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants and state encoding for the MEM-stage data memory controller.
package data_mem_ctrl_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Controller state, 2-bit encoding
  typedef enum logic [1:0] {
    DMC_IDLE     = 2'd0,
    DMC_REQ      = 2'd1,
    DMC_WAIT_RSP = 2'd2,
    DMC_DONE     = 2'd3
  } dmc_state_e;

endpackage

// File: rtl/data_mem_ctrl_lsu_align.sv
// Purely combinational load/store alignment: access legality, store strobes
// with lane replication, and load byte/half extraction with sign/zero extend.
module lsu_align
  import data_mem_ctrl_pkg::*;
(
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_data_rep,
  output logic        exc,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic       f3_ok;
  logic       misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Legality of the requested access; only meaningful when a request is present
  always_comb begin
    f3_ok = 1'b0;
    if (mem_read && !mem_write)
      f3_ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (funct3 == F3_LBU) || (funct3 == F3_LHU);
    else if (mem_write && !mem_read)
      f3_ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    misalign = 1'b0;
    if (funct3[1:0] == 2'b01)      misalign = addr_lo[0];
    else if (funct3[1:0] == 2'b10) misalign = (addr_lo != 2'b00);
    exc = (mem_read && mem_write) ||
          ((mem_read || mem_write) && (!f3_ok || misalign));
  end

  // Store byte enables and data replicated across every lane it may land in
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        st_strb     = 4'b0001 << addr_lo;
        st_data_rep = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_data_rep = {2{st_data[15:0]}};
      end
      default: begin
        st_strb     = 4'b1111;
        st_data_rep = st_data;
      end
    endcase
  end

  // Load lane select and extension, driven by the values captured at issue
  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage controller: issues one valid/ready bus transaction per load/store,
// stalls the pipeline while it is outstanding and holds the result until the
// instruction advances.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_MEM,
  input  logic                  mem_write_MEM,
  input  logic [2:0]            funct3_MEM,
  input  logic [ADDR_WIDTH-1:0] addr_MEM,
  input  logic [DATA_WIDTH-1:0] wdata_MEM,
  input  logic                  advance_MEM,
  output logic [DATA_WIDTH-1:0] rdata_MEM,
  output logic                  data_mem_hazard,
  output logic                  mem_exc_MEM,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_req_we,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic [DATA_WIDTH-1:0] bus_req_wdata,
  output logic [3:0]            bus_req_wstrb,
  input  logic                  bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rsp_rdata
);

  dmc_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [2:0]            ld_f3_q, ld_f3_d;
  logic [1:0]            ld_lo_q, ld_lo_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  access;
  logic [3:0]            st_strb;
  logic [DATA_WIDTH-1:0] st_data_rep;
  logic [DATA_WIDTH-1:0] ld_data;

  lsu_align u_align (
    .mem_read    (mem_read_MEM),
    .mem_write   (mem_write_MEM),
    .funct3      (funct3_MEM),
    .addr_lo     (addr_MEM[1:0]),
    .st_data     (wdata_MEM),
    .st_strb     (st_strb),
    .st_data_rep (st_data_rep),
    .exc         (mem_exc_MEM),
    .ld_funct3   (ld_f3_q),
    .ld_addr_lo  (ld_lo_q),
    .ld_raw      (bus_rsp_rdata),
    .ld_data     (ld_data)
  );

  assign access        = (mem_read_MEM ^ mem_write_MEM) && !mem_exc_MEM;
  assign bus_req_valid = (state_q == DMC_REQ);
  assign bus_req_we    = we_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_wstrb = wstrb_q;
  assign rdata_MEM     = rdata_q;

  // Next-state, request capture and stall generation
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    ld_f3_d         = ld_f3_q;
    ld_lo_d         = ld_lo_q;
    rdata_d         = rdata_q;
    data_mem_hazard = 1'b0;
    case (state_q)
      DMC_IDLE: begin
        data_mem_hazard = access;
        if (access) begin
          addr_d  = {addr_MEM[ADDR_WIDTH-1:2], 2'b00};
          we_d    = mem_write_MEM;
          wdata_d = st_data_rep;
          wstrb_d = mem_write_MEM ? st_strb : 4'b0000;
          ld_f3_d = funct3_MEM;
          ld_lo_d = addr_MEM[1:0];
          state_d = DMC_REQ;
        end
      end
      DMC_REQ: begin
        data_mem_hazard = 1'b1;
        if (bus_req_ready) state_d = DMC_WAIT_RSP;
      end
      DMC_WAIT_RSP: begin
        data_mem_hazard = 1'b1;
        if (bus_rsp_valid) begin
          if (!we_q) rdata_d = ld_data;
          state_d = DMC_DONE;
        end
      end
      DMC_DONE: begin
        // Wait for the instruction to leave so a frozen pipeline never re-issues
        if (advance_MEM) state_d = DMC_IDLE;
      end
      default: state_d = DMC_IDLE;
    endcase
  end

  // State and request/result registers; reset clears every bus-visible field
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DMC_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      ld_f3_q <= 3'b000;
      ld_lo_q <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ld_f3_q <= ld_f3_d;
      ld_lo_q <= ld_lo_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a cycle-scripted bus responder.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_MEM, mem_write_MEM, advance_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] addr_MEM, wdata_MEM, rdata_MEM;
  logic        data_mem_hazard, mem_exc_MEM;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;

  int n_chk = 0;
  int n_pass = 0;

  // results of the last scripted transaction
  int          t_hz, t_nreq;
  logic        t_stable;
  logic [31:0] t_addr, t_wdata;
  logic        t_we;
  logic [3:0]  t_wstrb;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read_MEM(mem_read_MEM), .mem_write_MEM(mem_write_MEM),
    .funct3_MEM(funct3_MEM), .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM),
    .advance_MEM(advance_MEM), .rdata_MEM(rdata_MEM),
    .data_mem_hazard(data_mem_hazard), .mem_exc_MEM(mem_exc_MEM),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Present one request, answer it after rdy_wait/rsp_wait cycles, return at the
  // negedge of the first non-stalled cycle (DONE). Inputs are scrambled once the
  // request has been sampled to show they are ignored while busy.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp_data,
                     input int rdy_wait, input int rsp_wait);
    logic accepted = 1'b0;
    logic done = 1'b0;
    int   wcnt = 0;
    t_hz = 0; t_nreq = 0; t_stable = 1'b1;
    @(posedge clk); #1;
    mem_read_MEM = rd; mem_write_MEM = wr; funct3_MEM = f3;
    addr_MEM = a; wdata_MEM = wd; advance_MEM = 1'b0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 1) begin addr_MEM = a ^ 32'h0000_0ff0; wdata_MEM = ~wd; end
      bus_rsp_valid = 1'b0;
      bus_req_ready = 1'b0;
      if (data_mem_hazard) t_hz++;
      else if (t_hz > 0) begin done = 1'b1; break; end
      if (accepted) begin
        wcnt++;
        if (wcnt == rsp_wait) begin bus_rsp_valid = 1'b1; bus_rsp_rdata = rsp_data; end
      end
      if (bus_req_valid) begin
        if (t_nreq == 0) begin
          t_addr = bus_req_addr; t_we = bus_req_we;
          t_wdata = bus_req_wdata; t_wstrb = bus_req_wstrb;
        end else if (bus_req_addr !== t_addr || bus_req_we !== t_we ||
                     bus_req_wdata !== t_wdata || bus_req_wstrb !== t_wstrb) begin
          t_stable = 1'b0;
        end
        bus_req_ready = (t_nreq >= rdy_wait);
        t_nreq++;
        if (bus_req_ready) accepted = 1'b1;
      end
    end
    if (!done) chk("txn_timeout", 32'd0, 32'd1);
  endtask

  // Let the instruction leave DONE and confirm the controller is idle again
  task automatic retire(input string tag);
    mem_read_MEM = 1'b0; mem_write_MEM = 1'b0; advance_MEM = 1'b1;
    @(negedge clk);
    advance_MEM = 1'b0;
    chk({tag, "_idle"}, 32'(dut.state_q), 32'(DMC_IDLE));
  endtask

  // Drive a request between clock edges, look at exc/hazard, then withdraw it
  task automatic probe(input string tag, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic exp_exc);
    @(negedge clk);
    mem_read_MEM = rd; mem_write_MEM = wr; funct3_MEM = f3; addr_MEM = a;
    #1;
    chk({tag, "_exc"}, 32'(mem_exc_MEM), 32'(exp_exc));
    chk({tag, "_hz"}, 32'(data_mem_hazard), 32'(!exp_exc));
    mem_read_MEM = 1'b0; mem_write_MEM = 1'b0;
  endtask

  initial begin
    logic seen_valid;
    rst = 1'b1;
    mem_read_MEM = 0; mem_write_MEM = 0; funct3_MEM = 0; addr_MEM = 0; wdata_MEM = 0;
    advance_MEM = 0; bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(dut.state_q), 32'(DMC_IDLE));
    chk("rst_valid", 32'(bus_req_valid), 32'd0);
    chk("rst_hz", 32'(data_mem_hazard), 32'd0);
    chk("rst_rdata", rdata_MEM, 32'd0);
    chk("rst_addr", bus_req_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SW, immediate ready and response
    txn(1'b0, 1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
    chk("sw_hz", t_hz, 3);
    chk("sw_addr", t_addr, 32'h100);
    chk("sw_wstrb", 32'(t_wstrb), 32'hF);
    chk("sw_we", 32'(t_we), 32'd1);
    chk("sw_wdata", t_wdata, 32'hDEADBEEF);
    chk("sw_done", 32'(dut.state_q), 32'(DMC_DONE));
    retire("sw");

    // LB / LBU of the top byte
    txn(1'b1, 1'b0, F3_LB, 32'h203, 32'h0, 32'h80FF_0000, 0, 1);
    chk("lb_rdata", rdata_MEM, 32'hFFFFFF80);
    chk("lb_addr", t_addr, 32'h200);
    chk("lb_we", 32'(t_we), 32'd0);
    retire("lb");
    txn(1'b1, 1'b0, F3_LBU, 32'h203, 32'h0, 32'h80FF_0000, 0, 1);
    chk("lbu_rdata", rdata_MEM, 32'h00000080);
    retire("lbu");

    // SH upper half, then LHU / LH
    txn(1'b0, 1'b1, F3_SH, 32'h102, 32'h0000ABCD, 32'h0, 0, 1);
    chk("sh_wstrb", 32'(t_wstrb), 32'hC);
    chk("sh_wdata", t_wdata, 32'hABCDABCD);
    chk("sh_addr", t_addr, 32'h100);
    retire("sh");
    txn(1'b1, 1'b0, F3_LHU, 32'h102, 32'h0, 32'h1234_5678, 0, 1);
    chk("lhu_rdata", rdata_MEM, 32'h00001234);
    retire("lhu");
    txn(1'b1, 1'b0, F3_LH, 32'h100, 32'h0, 32'h1234_8001, 0, 1);
    chk("lh_rdata", rdata_MEM, 32'hFFFF8001);
    retire("lh");

    // SB byte 1
    txn(1'b0, 1'b1, F3_SB, 32'h101, 32'h0000005A, 32'h0, 0, 1);
    chk("sb_wstrb", 32'(t_wstrb), 32'h2);
    chk("sb_wdata", t_wdata, 32'h5A5A5A5A);
    retire("sb");

    // Misaligned LW held for several cycles never reaches the bus
    @(posedge clk); #1;
    mem_read_MEM = 1'b1; funct3_MEM = F3_LW; addr_MEM = 32'h101;
    seen_valid = 1'b0;
    @(negedge clk);
    chk("lwmis_exc", 32'(mem_exc_MEM), 32'd1);
    chk("lwmis_hz", 32'(data_mem_hazard), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (bus_req_valid) seen_valid = 1'b1;
    end
    chk("lwmis_novalid", 32'(seen_valid), 32'd0);
    chk("lwmis_state", 32'(dut.state_q), 32'(DMC_IDLE));
    mem_read_MEM = 1'b0;

    probe("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h100, 1'b1);
    probe("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h100, 1'b1);
    probe("rd_and_wr", 1'b1, 1'b1, F3_LW, 32'h100, 1'b1);
    probe("sh_odd", 1'b0, 1'b1, F3_SH, 32'h101, 1'b1);
    probe("lbu_odd_ok", 1'b1, 1'b0, F3_LBU, 32'h103, 1'b0);
    probe("lh_2_ok", 1'b1, 1'b0, F3_LH, 32'h102, 1'b0);

    // LW with slow ready and slow response, then a frozen DONE
    txn(1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 32'hCAFEF00D, 4, 5);
    chk("slow_hz", t_hz, 11);
    chk("slow_nreq", t_nreq, 5);
    chk("slow_stable", 32'(t_stable), 32'd1);
    chk("slow_addr", t_addr, 32'h300);
    chk("slow_rdata", rdata_MEM, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus_req_valid), 32'd0);
      chk("hold_hz", 32'(data_mem_hazard), 32'd0);
      chk("hold_rdata", rdata_MEM, 32'hCAFEF00D);
    end
    retire("slow");

    // Reset while waiting for the response
    @(posedge clk); #1;
    mem_read_MEM = 1'b1; funct3_MEM = F3_LW; addr_MEM = 32'h400; bus_req_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rstw_pre", 32'(dut.state_q), 32'(DMC_WAIT_RSP));
    rst = 1'b1; mem_read_MEM = 1'b0; bus_req_ready = 1'b0;
    #1;
    chk("rstw_state", 32'(dut.state_q), 32'(DMC_IDLE));
    chk("rstw_valid", 32'(bus_req_valid), 32'd0);
    chk("rstw_hz", 32'(data_mem_hazard), 32'd0);
    chk("rstw_addr", bus_req_addr, 32'd0);
    chk("rstw_rdata", rdata_MEM, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h11111111;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_state", 32'(dut.state_q), 32'(DMC_IDLE));
    chk("late_rsp_hz", 32'(data_mem_hazard), 32'd0);
    chk("late_rsp_rdata", rdata_MEM, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
